// File: rtl/ps2_rx_wb_if.sv
// Wishbone slave bus bundle for the PS/2 receiver.
// The master drives the request signals and the slave returns the data and handshake.
interface ps2_rx_wb_if;
   logic [31:0] adr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  sel;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (output adr, wdata, sel, we, stb, cyc, input rdata, ack, err, rty);
   modport slave  (input adr, wdata, sel, we, stb, cyc, output rdata, ack, err, rty);
endinterface

// File: rtl/ps2_rx_wb.sv
// Receive-only PS/2 keyboard port: filtered clock, 11-bit deframer, 8-deep byte FIFO,
// Wishbone register window and a level interrupt.
module ps2_rx_wb #(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 5000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   ps2_rx_wb_if.slave  wb,
   input  logic        ps2_clk_pad_i,
   input  logic        ps2_dat_pad_i,
   output logic        int_o
);
   localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          fclk, bit_strobe;
   logic [FW-1:0] filt_cnt;

   state_t        state;
   logic [10:0]   frame;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] idle_cnt;
   logic          push_pend, perr_set, ferr_set;
   logic [7:0]    push_byte;

   logic [7:0]    mem [8];
   logic [2:0]    wr_ptr, rd_ptr;
   logic [3:0]    count;
   logic          ovr, perr, ferr, rxen, irqen;
   logic          ack_q, int_q;
   logic [31:0]   rdata_q, rd_mux;
   logic          req, commit, wr, wr_status, pop, do_push, full, rdy;
   logic          unused;

   assign full      = (count == 4'd8);
   assign rdy       = (count != 4'd0);
   assign req       = wb.stb & wb.cyc;
   assign commit    = req & ack_q;
   assign wr        = commit & wb.we;
   assign wr_status = wr & (wb.adr[3:2] == 2'd1);
   assign pop       = commit & ~wb.we & (wb.adr[3:2] == 2'd0) & rdy;
   assign do_push   = push_pend & ~full;

   assign wb.ack   = ack_q;
   assign wb.rdata = rdata_q;
   assign wb.err   = 1'b0;
   assign wb.rty   = 1'b0;
   assign int_o    = int_q;
   assign unused   = ^{wb.sel, wb.adr[31:4], wb.adr[1:0], wb.wdata[31:5]};

   // fclk only follows the synchronized clock after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         fclk       <= 1'b1;
         filt_cnt   <= '0;
         bit_strobe <= 1'b0;
      end else begin
         clk_s1     <= ps2_clk_pad_i;
         clk_s2     <= clk_s1;
         dat_s1     <= ps2_dat_pad_i;
         dat_s2     <= dat_s1;
         bit_strobe <= 1'b0;
         if (clk_s2 == fclk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            fclk       <= clk_s2;
            filt_cnt   <= '0;
            bit_strobe <= ~clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         frame     <= '0;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         push_pend <= 1'b0;
         perr_set  <= 1'b0;
         ferr_set  <= 1'b0;
         push_byte <= '0;
      end else begin
         push_pend <= 1'b0;
         perr_set  <= 1'b0;
         ferr_set  <= 1'b0;
         if (!rxen) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (bit_strobe) begin
                  frame    <= {dat_s2, frame[10:1]};
                  bit_cnt  <= 4'd1;
                  idle_cnt <= '0;
                  state    <= SHIFT;
               end
               SHIFT: if (bit_strobe) begin
                  frame    <= {dat_s2, frame[10:1]};
                  bit_cnt  <= bit_cnt + 4'd1;
                  idle_cnt <= '0;
                  if (bit_cnt == 4'd10) state <= DONE;
               end else if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  state <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
               DONE: begin
                  state     <= IDLE;
                  push_byte <= frame[8:1];
                  // Framing faults take precedence over a parity fault.
                  if (frame[0] || !frame[10]) ferr_set <= 1'b1;
                  else if (!(^frame[9:1]))    perr_set <= 1'b1;
                  else                        push_pend <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (wb.adr[3:2])
         2'd0:    rd_mux = rdy ? {24'b0, mem[rd_ptr]} : '0;
         2'd1:    rd_mux = {20'b0, count, 3'b0, ferr, perr, ovr, full, rdy};
         2'd2:    rd_mux = {30'b0, irqen, rxen};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_byte;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovr     <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         rxen    <= 1'b0;
         irqen   <= 1'b0;
         int_q   <= 1'b0;
      end else begin
         ack_q   <= req & ~ack_q;
         rdata_q <= (req & ~ack_q) ? rd_mux : '0;
         if (do_push) wr_ptr <= wr_ptr + 3'd1;
         if (pop)     rd_ptr <= rd_ptr + 3'd1;
         case ({do_push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
         // A set in the same cycle as a W1C clear wins.
         ovr  <= (push_pend & full) | (ovr  & ~(wr_status & wb.wdata[2]));
         perr <= perr_set           | (perr & ~(wr_status & wb.wdata[3]));
         ferr <= ferr_set           | (ferr & ~(wr_status & wb.wdata[4]));
         if (wr && wb.adr[3:2] == 2'd2) begin
            rxen  <= wb.wdata[0];
            irqen <= wb.wdata[1];
         end
         int_q <= irqen & (rdy | ovr | perr | ferr);
      end
   end
endmodule
